// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle LEGv8 control FSM: state codes, opcode
// patterns, opcode classes and ALU mux/operation selects.
package multicycle_control_pkg;

    localparam logic [3:0] S_INIT     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_EXEC     = 4'd7;
    localparam logic [3:0] S_R_WB     = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;

    // Opcode patterns (IR[31:21]); '?' bits are don't-care under casez.
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_LDURB = 11'b00111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_CBZ   = 11'b10110100???;
    localparam logic [10:0] OP_CBNZ  = 11'b10110101???;
    localparam logic [10:0] OP_B     = 11'b000101?????;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_LOADB   = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_CBZ     = 3'd4,
        CLS_CBNZ    = 3'd5,
        CLS_B       = 3'd6,
        CLS_ILLEGAL = 3'd7
    } op_class_t;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;
    localparam logic [1:0] SRC_B_SHL2 = 2'b11;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_PASS_B = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

endpackage

// File: rtl/multicycle_control_opcode_classifier.sv
// Combinational opcode decoder: maps IR[31:21] to the instruction class the
// sequencing FSM branches on.
module opcode_classifier
    import multicycle_control_pkg::*;
(
    input  logic [10:0] opcode_i,
    output op_class_t   op_class_o
);

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        op_class_o = CLS_ILLEGAL;
        casez (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: op_class_o = CLS_R;
            OP_LDUR:                        op_class_o = CLS_LOAD;
            OP_LDURB:                       op_class_o = CLS_LOADB;
            OP_STUR:                        op_class_o = CLS_STORE;
            OP_CBZ:                         op_class_o = CLS_CBZ;
            OP_CBNZ:                        op_class_o = CLS_CBNZ;
            OP_B:                           op_class_o = CLS_B;
            default:                        op_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 sequencer: walks each instruction through fetch/decode/
// execute/memory/writeback and drives the datapath controls from the state.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] opcode,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_source,
    output logic        iord,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_byte,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        readreg2_control,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        illegal_op
);

    logic [3:0] state_q, state_d;
    op_class_t  class_live;
    op_class_t  class_q;
    op_class_t  cls;

    opcode_classifier u_classifier (
        .opcode_i   (opcode),
        .op_class_o (class_live)
    );

    // The IR is only trusted in DECODE; later states use the latched class.
    assign cls = (state_q == S_DECODE) ? class_live : class_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            class_q <= CLS_ILLEGAL;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (state_q == S_DECODE) class_q <= class_live;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_write         = 1'b0;
        pc_write_cond    = 1'b0;
        pc_source        = 1'b0;
        iord             = 1'b0;
        ir_write         = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        mem_byte         = 1'b0;
        mem_to_reg       = 1'b0;
        reg_write        = 1'b0;
        readreg2_control = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = SRC_B_REG;
        alu_op           = ALU_OP_ADD;
        instr_done       = 1'b0;
        illegal_op       = 1'b0;

        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b        = SRC_B_SHL2;
                readreg2_control = (cls == CLS_STORE) || (cls == CLS_CBZ) || (cls == CLS_CBNZ);
                case (cls)
                    CLS_R:                          state_d = S_EXEC;
                    CLS_LOAD, CLS_LOADB, CLS_STORE: state_d = S_MEM_ADDR;
                    CLS_CBZ, CLS_CBNZ:              state_d = S_BRANCH;
                    CLS_B:                          state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_REG;
                alu_op    = ALU_OP_RTYPE;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a        = 1'b1;
                alu_src_b        = SRC_B_IMM;
                readreg2_control = (cls == CLS_STORE);
                state_d          = (cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                mem_byte = (cls == CLS_LOADB);
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write        = 1'b1;
                iord             = 1'b1;
                readreg2_control = 1'b1;
                instr_done       = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a        = 1'b1;
                alu_op           = ALU_OP_PASS_B;
                readreg2_control = 1'b1;
                pc_source        = 1'b1;
                instr_done       = 1'b1;
                pc_write_cond    = (cls == CLS_CBNZ) ? ~alu_zero : alu_zero;
                state_d          = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle pushes its
// hand-derived control vector, a monitor pops and compares mid-cycle.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] opcode = '0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, pc_source, iord, ir_write, mem_read;
    logic        mem_write, mem_byte, mem_to_reg, reg_write, readreg2_control;
    logic        alu_src_a, instr_done, illegal_op;
    logic [1:0]  alu_src_b, alu_op;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .iord(iord), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte(mem_byte), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .readreg2_control(readreg2_control),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Bit layout: pc_write pc_write_cond pc_source iord ir_write mem_read mem_write
    // mem_byte mem_to_reg reg_write readreg2 alu_src_a alu_src_b[1:0] alu_op[1:0] done illegal
    logic [17:0] act;
    assign act = {pc_write, pc_write_cond, pc_source, iord, ir_write, mem_read, mem_write,
                  mem_byte, mem_to_reg, reg_write, readreg2_control, alu_src_a,
                  alu_src_b, alu_op, instr_done, illegal_op};

    localparam logic [17:0] B_PCW  = 18'h20000;
    localparam logic [17:0] B_PCWC = 18'h10000;
    localparam logic [17:0] B_PSRC = 18'h08000;
    localparam logic [17:0] B_IORD = 18'h04000;
    localparam logic [17:0] B_IRW  = 18'h02000;
    localparam logic [17:0] B_MRD  = 18'h01000;
    localparam logic [17:0] B_MWR  = 18'h00800;
    localparam logic [17:0] B_MBY  = 18'h00400;
    localparam logic [17:0] B_M2R  = 18'h00200;
    localparam logic [17:0] B_RGW  = 18'h00100;
    localparam logic [17:0] B_RR2  = 18'h00080;
    localparam logic [17:0] B_SRCA = 18'h00040;
    localparam logic [17:0] B_SB4  = 18'h00010;
    localparam logic [17:0] B_SBI  = 18'h00020;
    localparam logic [17:0] B_SBS  = 18'h00030;
    localparam logic [17:0] B_OPP  = 18'h00004;
    localparam logic [17:0] B_OPR  = 18'h00008;
    localparam logic [17:0] B_DONE = 18'h00002;
    localparam logic [17:0] B_ILL  = 18'h00001;

    localparam logic [17:0] E_ZERO     = 18'h0;
    localparam logic [17:0] E_FETCH_W  = B_MRD | B_SB4;
    localparam logic [17:0] E_FETCH_R  = B_MRD | B_SB4 | B_IRW | B_PCW;
    localparam logic [17:0] E_DEC      = B_SBS;
    localparam logic [17:0] E_DEC_RR2  = B_SBS | B_RR2;
    localparam logic [17:0] E_DEC_ILL  = B_SBS | B_DONE | B_ILL;
    localparam logic [17:0] E_EXEC     = B_SRCA | B_OPR;
    localparam logic [17:0] E_R_WB     = B_RGW | B_DONE;
    localparam logic [17:0] E_MADDR    = B_SRCA | B_SBI;
    localparam logic [17:0] E_MADDR_ST = B_SRCA | B_SBI | B_RR2;
    localparam logic [17:0] E_MRD      = B_MRD | B_IORD;
    localparam logic [17:0] E_MRD_B    = B_MRD | B_IORD | B_MBY;
    localparam logic [17:0] E_MWB      = B_RGW | B_M2R | B_DONE;
    localparam logic [17:0] E_MWR_W    = B_MWR | B_IORD | B_RR2;
    localparam logic [17:0] E_MWR_R    = B_MWR | B_IORD | B_RR2 | B_DONE;
    localparam logic [17:0] E_BR_T     = B_SRCA | B_OPP | B_RR2 | B_PSRC | B_DONE | B_PCWC;
    localparam logic [17:0] E_BR_N     = B_SRCA | B_OPP | B_RR2 | B_PSRC | B_DONE;
    localparam logic [17:0] E_JUMP     = B_PCW | B_PSRC | B_DONE;

    localparam logic [10:0] ADD   = 11'b10001011000;
    localparam logic [10:0] LDUR  = 11'b11111000010;
    localparam logic [10:0] LDURB = 11'b00111000010;
    localparam logic [10:0] STUR  = 11'b11111000000;
    localparam logic [10:0] CBZ   = 11'b10110100101;
    localparam logic [10:0] CBNZ  = 11'b10110101011;
    localparam logic [10:0] BR    = 11'b00010110011;
    localparam logic [10:0] ILL   = 11'b00000000000;

    logic [17:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %05h expected %05h", name, got, want);
    endtask

    // One clock cycle of stimulus; inputs change just after the rising edge.
    task automatic step(input logic rst, input logic [10:0] op, input logic z,
                        input logic rdy, input logic [17:0] want, input string name);
        @(posedge clk);
        #1;
        rst_n     = rst;
        opcode    = op;
        alu_zero  = z;
        mem_ready = rdy;
        exp_q.push_back(want);
        name_q.push_back(name);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check(name_q.pop_front(), act, exp_q.pop_front());
        end
    end

    initial begin : stimulus
        // Reset held, then one INIT cycle after release
        step(0, ADD, 0, 1, E_ZERO, "reset_hold0");
        step(0, ADD, 0, 1, E_ZERO, "reset_hold1");
        step(1, ADD, 0, 1, E_ZERO, "init_after_release");

        // ADD, zero-wait: 4 cycles
        step(1, ADD, 0, 1, E_FETCH_R, "add_fetch");
        step(1, ADD, 0, 1, E_DEC,     "add_decode");
        step(1, ADD, 0, 1, E_EXEC,    "add_exec");
        step(1, ADD, 0, 1, E_R_WB,    "add_rwb");

        // LDURB, two wait cycles in FETCH and in MEM_RD: 9 cycles
        step(1, LDURB, 0, 0, E_FETCH_W, "ldurb_fetch_wait0");
        step(1, LDURB, 0, 0, E_FETCH_W, "ldurb_fetch_wait1");
        step(1, LDURB, 0, 1, E_FETCH_R, "ldurb_fetch_rdy");
        step(1, LDURB, 0, 1, E_DEC,     "ldurb_decode");
        step(1, LDURB, 0, 0, E_MADDR,   "ldurb_maddr");
        step(1, LDURB, 0, 0, E_MRD_B,   "ldurb_mrd_wait0");
        step(1, LDURB, 0, 0, E_MRD_B,   "ldurb_mrd_wait1");
        step(1, LDURB, 0, 1, E_MRD_B,   "ldurb_mrd_rdy");
        step(1, LDURB, 0, 1, E_MWB,     "ldurb_mwb");

        // Conditional branches, all four zero/opcode combinations
        step(1, CBZ, 1, 1, E_FETCH_R, "cbz1_fetch");
        step(1, CBZ, 1, 1, E_DEC_RR2, "cbz1_decode");
        step(1, CBZ, 1, 1, E_BR_T,    "cbz1_branch_taken");
        step(1, CBNZ, 1, 1, E_FETCH_R, "cbnz1_fetch");
        step(1, CBNZ, 1, 1, E_DEC_RR2, "cbnz1_decode");
        step(1, CBNZ, 1, 1, E_BR_N,    "cbnz1_branch_not_taken");
        step(1, CBZ, 0, 1, E_FETCH_R, "cbz0_fetch");
        step(1, CBZ, 0, 1, E_DEC_RR2, "cbz0_decode");
        step(1, CBZ, 0, 1, E_BR_N,    "cbz0_branch_not_taken");
        step(1, CBNZ, 0, 1, E_FETCH_R, "cbnz0_fetch");
        step(1, CBNZ, 0, 1, E_DEC_RR2, "cbnz0_decode");
        step(1, CBNZ, 0, 0, E_BR_T,    "cbnz0_branch_taken");

        // STUR, mem_ready ignored in DECODE/MEM_ADDR, two waits in MEM_WR
        step(1, STUR, 0, 1, E_FETCH_R,  "stur_fetch");
        step(1, STUR, 0, 0, E_DEC_RR2,  "stur_decode");
        step(1, STUR, 0, 1, E_MADDR_ST, "stur_maddr");
        step(1, STUR, 0, 0, E_MWR_W,    "stur_mwr_wait0");
        step(1, STUR, 0, 0, E_MWR_W,    "stur_mwr_wait1");
        step(1, STUR, 0, 1, E_MWR_R,    "stur_mwr_rdy");

        // LDUR with the IR changed to B after DECODE: class must stay latched
        step(1, LDUR, 0, 1, E_FETCH_R, "ldur_fetch");
        step(1, LDUR, 0, 1, E_DEC,     "ldur_decode");
        step(1, BR,   0, 1, E_MADDR,   "ldur_maddr_ir_changed");
        step(1, STUR, 0, 1, E_MRD,     "ldur_mrd_ir_changed");
        step(1, ILL,  0, 1, E_MWB,     "ldur_mwb_ir_changed");

        // Illegal opcode: 2 cycles
        step(1, ILL, 0, 1, E_FETCH_R, "ill_fetch");
        step(1, ILL, 0, 1, E_DEC_ILL, "ill_decode");

        // Back-to-back B
        step(1, BR, 0, 1, E_FETCH_R, "b0_fetch");
        step(1, BR, 0, 1, E_DEC,     "b0_decode");
        step(1, BR, 0, 1, E_JUMP,    "b0_jump");
        step(1, BR, 0, 1, E_FETCH_R, "b1_fetch");
        step(1, BR, 0, 1, E_DEC,     "b1_decode");
        step(1, BR, 0, 1, E_JUMP,    "b1_jump");

        // Reset asserted mid MEM_RD wait, then recovery
        step(1, LDUR, 0, 1, E_FETCH_R, "rst_ldur_fetch");
        step(1, LDUR, 0, 1, E_DEC,     "rst_ldur_decode");
        step(1, LDUR, 0, 1, E_MADDR,   "rst_ldur_maddr");
        step(1, LDUR, 0, 0, E_MRD,     "rst_ldur_mrd_wait");
        step(0, LDUR, 0, 1, E_ZERO,    "rst_async_mid_mrd");
        step(1, LDUR, 0, 1, E_ZERO,    "rst_init_after_release");
        step(1, LDUR, 0, 1, E_FETCH_R, "rst_first_fetch");

        begin : drain
            int waited = 0;
            while (exp_q.size() > 0 && waited < 10) begin
                @(posedge clk);
                waited++;
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing FSM for the multicycle LEGv8 datapath; it replaces the single-cycle opcode decoder. One instruction moves through fetch, decode, execute, memory and writeback states, with a shared ALU and a single unified memory port. Memory accesses use a ready handshake, so wait states are tolerated. The block drives every datapath mux, write enable and memory strobe from its current state and the latched opcode.

## Interface
- No parameters; opcode and state encodings come from `constants.vh`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `opcode` in 11: `IR[31:21]`, valid from DECODE onward.
- `alu_zero` in 1: ALU zero flag of the current cycle.
- `mem_ready` in 1: memory has completed the access presented this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load, qualified internally by branch result (see BRANCH).
- `pc_source` out 1: 0 = ALU result, 1 = ALUOut register (branch target).
- `iord` out 1: memory address, 0 = PC, 1 = ALUOut.
- `ir_write` out 1.
- `mem_read` out 1.
- `mem_write` out 1.
- `mem_byte` out 1: byte access (LDURB).
- `mem_to_reg` out 1.
- `reg_write` out 1.
- `readreg2_control` out 1: read-register-2 source is Rt.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `alu_op` out 2: 00 = add, 01 = pass B, 10 = R-type function.
- `instr_done` out 1: single-cycle pulse in an instruction's final cycle.
- `illegal_op` out 1: single-cycle pulse on an undecodable opcode.

## Operation
- States: INIT, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, BRANCH, JUMP.
- Moore decode: outputs are a function of state, the opcode class, and `mem_ready`/`alu_zero` where noted. Every output not listed for a state is 0.
- **INIT:** all outputs 0. Next state is FETCH.
- **FETCH:** `mem_read`, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stay in FETCH until `mem_ready`, then go to DECODE.
- **DECODE:** `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target goes to ALUOut). `readreg2_control` = 1 for STUR/CBZ/CBNZ. Next state by class:
  - R-type → EXEC.
  - LDUR, LDURB, STUR → MEM_ADDR.
  - CBZ, CBNZ → BRANCH.
  - B → JUMP.
  - Illegal → FETCH, with `illegal_op`=1 and `instr_done`=1.
- **EXEC:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state is R_WB.
- **R_WB:** `reg_write`, `instr_done`. Next state is FETCH.
- **MEM_ADDR:** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00, plus `readreg2_control` for STUR.
  - Load → MEM_RD.
  - Store → MEM_WR.
- **MEM_RD:** `mem_read`, `iord`=1, `mem_byte` for LDURB. Hold until `mem_ready`, then go to MEM_WB.
- **MEM_WB:** `reg_write`, `mem_to_reg`, `instr_done`. Next state is FETCH.
- **MEM_WR:** `mem_write`, `iord`=1, `readreg2_control`.
  - On `mem_ready`: `instr_done`=1 and next state is FETCH.
  - Otherwise hold.
- **BRANCH:** `alu_src_a`=1, `alu_op`=01, `readreg2_control`, `pc_source`=1, `instr_done`.
  - `pc_write_cond` = `alu_zero` for CBZ, `~alu_zero` for CBNZ.
  - Next state is FETCH.
- **JUMP:** `pc_write`, `pc_source`=1, `instr_done`. Next state is FETCH.
- Opcode class is latched at DECODE and held until `instr_done`, so IR changes cannot alter an in-flight instruction.

## Timing
- Reset: state goes to INIT asynchronously; every output is 0 while `rst_n`=0. The first FETCH occurs one cycle after release.
- Zero-wait latency (cycles from FETCH to `instr_done` inclusive):
  - R-type: 4.
  - LDUR/LDURB: 5.
  - STUR: 4.
  - CBZ/CBNZ: 3.
  - B: 3.
  - Illegal: 2.
- Each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- Strobes (`mem_read`, `mem_write`, `iord`, `mem_byte`) stay stable while waiting.
- `ir_write` and `pc_write` assert only in the `mem_ready` cycle.
- `mem_ready` is ignored in every state other than FETCH, MEM_RD and MEM_WR.
- Reset asserted mid-access drops all strobes immediately, with no completion pulse.

## Structure
- `constants.vh` receives:
  - the state encoding localparams (4-bit);
  - the opcode class codes (R, LOAD, LOADB, STORE, CBZ, CBNZ, B, ILLEGAL);
  - the `alu_src_b` and `alu_op` encodings.
- Opcode `casex` patterns reuse the existing `constants.vh` opcode defines.
- Sub-module `opcode_classifier`: combinational, maps `opcode` to the class code. The FSM stays in `multicycle_control`.

## Test plan
- **ADD**, opcode 10001011000, `mem_ready` always 1: states FETCH, DECODE, EXEC, R_WB. `reg_write`=1 only in cycle 4, together with `instr_done`.
- **LDURB**, opcode 00111000010, `mem_ready` low 2 cycles in both FETCH and MEM_RD: 9 cycles total. `mem_byte`=1 throughout MEM_RD. `mem_to_reg`=1 and `reg_write`=1 only in MEM_WB.
- **Conditional branches:**
  - CBZ, opcode 10110100xxx, `alu_zero`=1: `pc_write_cond`=1 in cycle 3.
  - CBNZ with `alu_zero`=1: `pc_write_cond`=0, `instr_done`=1.
- **STUR**, opcode 11111000000: `mem_write` held with `iord`=1 until `mem_ready`. `readreg2_control`=1 in DECODE, MEM_ADDR and MEM_WR. No `reg_write` in any cycle.
- **Illegal opcode** 00000000000: `illegal_op` and `instr_done` pulse in DECODE, then return to FETCH. Back-to-back B, opcode 000101xxxxx: `pc_write`=1 with `pc_source`=1 every third cycle.
- **Reset** (`rst_n` low) asserted mid-MEM_RD: all outputs 0 asynchronously. One INIT cycle after release, then FETCH with `mem_read`=1.
